// File: rtl/distribute_1x2_ctrl_pkg.sv
// Shared definitions for the 1-to-2 distribute controller: command encodings,
// lane mask type and small helpers used by the controller and its steering logic.
package distribute_1x2_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned CMD_WIDTH_DEFAULT  = 2;
  localparam int unsigned NUM_LANES          = 2;
  localparam int unsigned DROP_CNT_WIDTH     = 8;

  // Each command bit addresses one lane, so the command doubles as the lane mask.
  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_LOW  = 2'b01,
    CMD_HIGH = 2'b10,
    CMD_DUP  = 2'b11
  } cmd_e;

  typedef logic [NUM_LANES-1:0]      lane_mask_t;
  typedef logic [DROP_CNT_WIDTH-1:0] drop_cnt_t;

  function automatic lane_mask_t cmd_to_mask(input cmd_e cmd);
    return lane_mask_t'(cmd);
  endfunction

  function automatic drop_cnt_t sat_inc(input drop_cnt_t value);
    return (value == '1) ? value : value + drop_cnt_t'(1);
  endfunction

endpackage

// File: rtl/distribute_1x2_ctrl_if.sv
// Upstream/downstream handshake bundle of the 1-to-2 distribute controller.
// master = the side driving beats and downstream ready; slave = the controller.
interface distribute_1x2_ctrl_if
  import distribute_1x2_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int unsigned COMMMAND_WIDTH = CMD_WIDTH_DEFAULT
);

  logic                        i_valid;
  logic [DATA_WIDTH-1:0]       i_data_bus;
  logic [COMMMAND_WIDTH-1:0]   i_cmd;
  logic                        o_ready;
  logic [NUM_LANES-1:0]        o_valid;
  logic [2*DATA_WIDTH-1:0]     o_data_bus;
  logic [NUM_LANES-1:0]        i_ready;
  logic                        o_busy;
  logic [DROP_CNT_WIDTH-1:0]   o_drop_cnt;

  modport master (
    output i_valid,
    output i_data_bus,
    output i_cmd,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_data_bus,
    input  o_busy,
    input  o_drop_cnt
  );

  modport slave (
    input  i_valid,
    input  i_data_bus,
    input  i_cmd,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_data_bus,
    output o_busy,
    output o_drop_cnt
  );

endinterface

// File: rtl/distribute_1x2_simple_comb.sv
// Combinational 1-to-2 lane steering: copies the payload onto every lane
// selected by the command while the input is valid and enabled.
module distribute_1x2_simple_comb
  import distribute_1x2_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                          i_valid,
  input  logic                          i_en,
  input  logic [NUM_LANES-1:0]          i_cmd,
  input  logic [DATA_WIDTH-1:0]         i_data,
  output logic [NUM_LANES-1:0]          o_valid,
  output logic [NUM_LANES*DATA_WIDTH-1:0] o_data
);

  always_comb begin
    o_valid = '0;
    o_data  = '0;
    if (i_valid && i_en) begin
      o_valid = i_cmd;
      for (int unsigned lane = 0; lane < NUM_LANES; lane++) begin
        if (i_cmd[lane]) begin
          o_data[lane*DATA_WIDTH +: DATA_WIDTH] = i_data;
        end
      end
    end
  end

endmodule

// File: rtl/distribute_1x2_ctrl.sv
// Single-entry 1-to-2 distribute controller: holds one beat plus a pending lane
// mask, forks duplicates lane by lane, and counts dropped (cmd 00) beats.
module distribute_1x2_ctrl
  import distribute_1x2_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int unsigned COMMMAND_WIDTH = CMD_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  distribute_1x2_ctrl_if.slave  bus
);

  lane_mask_t            pending_q;
  lane_mask_t            pending_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  drop_cnt_t             drop_cnt_q;
  drop_cnt_t             drop_cnt_d;

  lane_mask_t            remaining;
  logic                  ready;
  logic                  accept;
  cmd_e                  cmd;

  lane_mask_t                    steer_valid;
  logic [NUM_LANES*DATA_WIDTH-1:0] steer_data;

  assign cmd = cmd_e'(bus.i_cmd[1:0]);

  // Lanes still owed after this cycle's transfers; the entry frees when none remain,
  // so o_ready never looks at i_valid.
  always_comb begin
    remaining  = pending_q & ~bus.i_ready;
    ready      = (remaining == '0);
    accept     = bus.i_valid & ready;
    pending_d  = remaining;
    data_d     = data_q;
    drop_cnt_d = drop_cnt_q;
    if (accept) begin
      if (cmd == CMD_NONE) begin
        drop_cnt_d = sat_inc(drop_cnt_q);
      end else begin
        pending_d = cmd_to_mask(cmd);
        data_d    = bus.i_data_bus;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      data_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      data_q     <= data_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  distribute_1x2_simple_comb #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_steer (
    .i_valid (|pending_q),
    .i_en    (1'b1),
    .i_cmd   (pending_q),
    .i_data  (data_q),
    .o_valid (steer_valid),
    .o_data  (steer_data)
  );

  // Outputs are re-gated with the pending mask so idle lanes read zero
  // regardless of how the steering block treats unselected lanes.
  always_comb begin
    bus.o_valid    = steer_valid & pending_q;
    bus.o_data_bus = '0;
    for (int unsigned lane = 0; lane < NUM_LANES; lane++) begin
      if (pending_q[lane]) begin
        bus.o_data_bus[lane*DATA_WIDTH +: DATA_WIDTH] =
          steer_data[lane*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_busy     = |pending_q;
  assign bus.o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_distribute_1x2_ctrl.sv
// Self-checking bench for distribute_1x2_ctrl: directed scenarios plus a
// per-lane scoreboard fed at acceptance and drained at lane transfers.
module tb_distribute_1x2_ctrl;
  import distribute_1x2_ctrl_pkg::*;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  distribute_1x2_ctrl_if #(.DATA_WIDTH(DW), .COMMMAND_WIDTH(2)) bus ();

  distribute_1x2_ctrl #(
    .DATA_WIDTH     (DW),
    .COMMMAND_WIDTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q_low[$];
  logic [DW-1:0] q_high[$];
  logic [7:0]    drop_model = '0;
  logic [1:0]    stall = '0;
  logic          mon_en = 1'b0;

  // Scoreboard monitor: pops on each lane transfer, pushes on each acceptance.
  always @(negedge clk) begin : monitor
    logic [DW-1:0] lane_d;
    logic [DW-1:0] exp_d;
    logic          have;
    if (rst || !mon_en) begin
      if (rst) begin
        q_low.delete();
        q_high.delete();
        drop_model = '0;
      end
      stall = '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        lane_d = bus.o_data_bus[b*DW +: DW];
        checks++;
        if (stall[b] && !bus.o_valid[b]) begin
          errors++;
          $display("FAIL valid_hold lane%0d: o_valid=0, required 1 until transfer", b);
        end
        if (!bus.o_valid[b]) begin
          checks++;
          if (lane_d !== '0) begin
            errors++;
            $display("FAIL idle_lane_zero lane%0d: got %h, required 0", b, lane_d);
          end
        end else if (bus.i_ready[b]) begin
          have  = 1'b0;
          exp_d = '0;
          if (b == 0 && q_low.size() > 0) begin
            exp_d = q_low.pop_front();
            have  = 1'b1;
          end
          if (b == 1 && q_high.size() > 0) begin
            exp_d = q_high.pop_front();
            have  = 1'b1;
          end
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL sb_unexpected lane%0d: got %h, required no transfer", b, lane_d);
          end else if (lane_d !== exp_d) begin
            errors++;
            $display("FAIL sb_data lane%0d: got %h, required %h", b, lane_d, exp_d);
          end
        end
      end
      stall = bus.o_valid & ~bus.i_ready;
      checks++;
      if (bus.o_drop_cnt !== drop_model) begin
        errors++;
        $display("FAIL drop_cnt: got %0d, required %0d", bus.o_drop_cnt, drop_model);
      end
      if (bus.i_valid && bus.o_ready) begin
        if (bus.i_cmd == 2'b00) begin
          if (drop_model != 8'hFF) drop_model = drop_model + 8'd1;
        end
        if (bus.i_cmd[0]) q_low.push_back(bus.i_data_bus);
        if (bus.i_cmd[1]) q_high.push_back(bus.i_data_bus);
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] c, input logic [DW-1:0] d,
                       input logic [1:0] r);
    @(posedge clk);
    #1;
    bus.i_valid    = v;
    bus.i_cmd      = c;
    bus.i_data_bus = d;
    bus.i_ready    = r;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.i_valid    = 1'b0;
    bus.i_cmd      = 2'b00;
    bus.i_data_bus = '0;
    bus.i_ready    = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_valid !== 2'b00 || bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1 ||
        bus.o_data_bus !== '0 || bus.o_drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b ready=%b data=%h drop=%0d, required 00 0 1 0 0",
               bus.o_valid, bus.o_busy, bus.o_ready, bus.o_data_bus, bus.o_drop_cnt);
    end
  endtask

  task automatic test_single_low();
    drive(1'b1, 2'b01, 32'hA5A5A5A5, 2'b11);
    @(negedge clk);
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b, required 1", bus.o_ready);
    end
    drive(1'b0, 2'b00, '0, 2'b11);
    @(negedge clk);
    checks++;
    if (bus.o_valid !== 2'b01 || bus.o_data_bus !== {32'h0, 32'hA5A5A5A5}) begin
      errors++;
      $display("FAIL single_out: valid=%b data=%h, required 01 %h",
               bus.o_valid, bus.o_data_bus, {32'h0, 32'hA5A5A5A5});
    end
    drive(1'b0, 2'b00, '0, 2'b11);
    @(negedge clk);
    checks++;
    if (bus.o_valid !== 2'b00 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: valid=%b busy=%b, required 00 0", bus.o_valid, bus.o_busy);
    end
  endtask

  task automatic test_partial_fork();
    drive(1'b1, 2'b11, 32'h11, 2'b01);
    @(negedge clk);
    drive(1'b0, 2'b00, '0, 2'b01);
    @(negedge clk);
    checks++;
    if (bus.o_valid !== 2'b11 || bus.o_ready !== 1'b0 || bus.o_data_bus !== {32'h11, 32'h11}) begin
      errors++;
      $display("FAIL fork_cycle1: valid=%b ready=%b data=%h, required 11 0 both 11",
               bus.o_valid, bus.o_ready, bus.o_data_bus);
    end
    for (int i = 2; i <= 3; i++) begin
      drive(1'b0, 2'b00, '0, 2'b01);
      @(negedge clk);
      checks++;
      if (bus.o_valid !== 2'b10 || bus.o_ready !== 1'b0 || bus.o_data_bus !== {32'h11, 32'h0}) begin
        errors++;
        $display("FAIL fork_hold_c%0d: valid=%b ready=%b data=%h, required 10 0 high 11",
                 i, bus.o_valid, bus.o_ready, bus.o_data_bus);
      end
    end
    drive(1'b0, 2'b00, '0, 2'b11);
    @(negedge clk);
    checks++;
    if (bus.o_valid !== 2'b10 || bus.o_ready !== 1'b1 || bus.o_data_bus !== {32'h11, 32'h0}) begin
      errors++;
      $display("FAIL fork_c4: valid=%b ready=%b data=%h, required 10 1 high 11",
               bus.o_valid, bus.o_ready, bus.o_data_bus);
    end
    drive(1'b0, 2'b00, '0, 2'b11);
    @(negedge clk);
    checks++;
    if (bus.o_valid !== 2'b00) begin
      errors++;
      $display("FAIL fork_done: valid=%b, required 00", bus.o_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] cmds[3];
    cmds[0] = 2'b10;
    cmds[1] = 2'b01;
    cmds[2] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(1'b1, cmds[k], 32'h100 + k, 2'b11);
      else       drive(1'b0, 2'b00, '0, 2'b11);
      @(negedge clk);
      checks++;
      if (bus.o_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_c%0d: got %b, required 1", k, bus.o_ready);
      end
      if (k > 0) begin
        checks++;
        if (bus.o_valid !== cmds[k-1]) begin
          errors++;
          $display("FAIL b2b_valid_c%0d: got %b, required %b", k, bus.o_valid, cmds[k-1]);
        end
      end
    end
  endtask

  task automatic test_drop_saturate();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'b00, $urandom, 2'($urandom_range(0, 3)));
      @(negedge clk);
      checks++;
      if (bus.o_valid !== 2'b00 || bus.o_ready !== 1'b1) begin
        errors++;
        $display("FAIL drop_idle_%0d: valid=%b ready=%b, required 00 1", i, bus.o_valid, bus.o_ready);
      end
    end
    drive(1'b0, 2'b00, '0, 2'b11);
    @(negedge clk);
    checks++;
    if (bus.o_drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL drop_saturate: got %0d, required 255", bus.o_drop_cnt);
    end
  endtask

  task automatic test_reset_mid_fork();
    drive(1'b1, 2'b11, 32'hDEAD, 2'b01);
    @(negedge clk);
    drive(1'b0, 2'b00, '0, 2'b01);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst            = 1'b1;
    bus.i_valid    = 1'b1;
    bus.i_cmd      = 2'b01;
    bus.i_data_bus = 32'hBEEF;
    bus.i_ready    = 2'b00;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_valid !== 2'b00 || bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1 ||
        bus.o_drop_cnt !== 8'd0 || bus.o_data_bus !== '0) begin
      errors++;
      $display("FAIL reset_mid_fork: valid=%b busy=%b ready=%b drop=%0d data=%h, required 00 0 1 0 0",
               bus.o_valid, bus.o_busy, bus.o_ready, bus.o_drop_cnt, bus.o_data_bus);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
            2'($urandom_range(0, 3)));
    end
    drive(1'b0, 2'b00, '0, 2'b11);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (q_low.size() != 0 || q_high.size() != 0 || bus.o_valid !== 2'b00) begin
      errors++;
      $display("FAIL random_drain: low_left=%0d high_left=%0d valid=%b, required 0 0 00",
               q_low.size(), q_high.size(), bus.o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_low();
    test_partial_fork();
    test_back_to_back();
    test_drop_saturate();
    test_reset_mid_fork();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/distribute_1x2_ctrl.md
DISTRIBUTE_1X2_CTRL -- requirements
Module: distribute_1x2_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, payload width per lane.
REQ-002 Parameter COMMMAND_WIDTH, default 2, routing command width: 00 drop, 01 low, 10 high, 11 duplicate.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port i_valid  input  1  upstream beat valid.
REQ-006 Port i_data_bus  input  DATA_WIDTH  upstream payload.
REQ-007 Port i_cmd  input  COMMMAND_WIDTH  routing command, qualified by i_valid.
REQ-008 Port o_ready  output  1  upstream may transfer; a beat is accepted when i_valid & o_ready.
REQ-009 Port o_valid  output  2  per-lane valid, bit1 high lane, bit0 low lane.
REQ-010 Port o_data_bus  output  2*DATA_WIDTH  {high lane, low lane} payload.
REQ-011 Port i_ready  input  2  per-lane downstream ready, same bit order as o_valid.
REQ-012 Port o_busy  output  1  holding register occupied.
REQ-013 Port o_drop_cnt  output  8  saturating count of accepted cmd-00 beats.

Function
REQ-014 The block SHALL hold one entry: data register plus 2-bit pending mask; the entry is full iff pending != 00.
REQ-015 Lane b transfer SHALL occur when o_valid[b] & i_ready[b]; the pending bit clears on the next edge.
REQ-016 o_valid SHALL equal the pending mask; o_busy SHALL equal (pending != 00).
REQ-017 o_data_bus SHALL carry the held data on each pending lane and zeros on every non-pending lane; all zeros when empty.
REQ-018 o_ready SHALL be 1 when empty or when every pending lane transfers this cycle ((pending & ~i_ready) == 00); otherwise 0.
REQ-019 On acceptance of cmd 01/10/11 the entry SHALL load data and pending = i_cmd; first o_valid is the next cycle (latency 1).
REQ-020 Simultaneous completion and acceptance SHALL reload in the same edge: sustained throughput one beat per cycle.
REQ-021 Duplicate with one lane ready: that lane SHALL complete alone (partial fork); the other lane SHALL stay valid with unchanged data until it transfers; the data register SHALL NOT change while pending != 00 except on reload.
REQ-022 No lane SHALL receive the same entry twice; no lane SHALL be dropped.
REQ-023 Accepted cmd 00 SHALL produce no output, leave the entry unchanged except for any completion, and increment o_drop_cnt, saturating at 255.
REQ-024 o_valid[b] SHALL NOT deassert before transfer; held data SHALL stay stable while valid (AXI-style rule).
REQ-025 i_ready SHALL NOT be required to depend on o_valid; o_ready SHALL NOT depend combinationally on i_valid.

Reset
REQ-026 On rst at a rising edge: pending = 00, data register = 0, o_drop_cnt = 0; next cycle o_valid = 00, o_data_bus = 0, o_busy = 0, o_ready = 1.
REQ-027 Reset mid-operation SHALL discard the held entry, including a partially forked duplicate, without completing it.
REQ-028 A beat presented during a reset cycle SHALL NOT be accepted.

Structure
REQ-029 Command encodings (CMD_NONE, CMD_LOW, CMD_HIGH, CMD_DUP) SHALL live in a shared package with DATA_WIDTH default.
REQ-030 Lane steering SHALL instantiate one distribute_1x2_simple_comb with i_valid = busy, i_en = 1, and i_cmd = pending mask. The controller SHALL gate its outputs with the pending mask so REQ-017 holds independent of sub-module latching.
REQ-031 Pending mask, data register and drop counter SHALL be the only state; no FSM beyond the empty/partial/full mask encoding.

Verification
REQ-032 Send 0xA5A5A5A5, cmd 01, i_ready = 11. Expect: next cycle o_valid = 01, low lane 0xA5A5A5A5, high lane 0; then empty.
REQ-033 Send 0x11, cmd 11, i_ready = 01 for 3 cycles then 11. Expect: low transfers cycle 1; o_valid = 10 holding 0x11 for cycles 2-4; o_ready = 0 until the high transfer.
REQ-034 Back-to-back cmds 10, 01, 11 with i_ready = 11. Expect: o_ready held 1; o_valid sequence 10, 01, 11 on consecutive cycles.
REQ-035 Send 300 beats of cmd 00. Expect: o_valid stays 00; o_drop_cnt reaches 255 and holds.
REQ-036 Load cmd 11, complete only the low lane, then assert rst one cycle. Expect: o_valid = 00, o_busy = 0, o_ready = 1, o_drop_cnt = 0 on the following cycle.
REQ-037 Random i_ready with a scoreboard. Expect: each lane receives exactly the beats addressed to it, in order; no drops; no duplicates.
